// File: rtl/usb4_dec_pkg.sv
// Shared encodings for the USB4 receive lane decoder: speed modes,
// sync header values, Gen4 block-type select and block sizing.
package usb4_dec_pkg;

    typedef enum logic [1:0] {
        GEN4     = 2'd0,
        GEN3     = 2'd1,
        GEN2     = 2'd2,
        GEN_RSVD = 2'd3
    } gen_speed_e;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_SERIAL = 1'b1
    } dec_state_e;

    localparam logic [1:0] SH2_DATA   = 2'b01;
    localparam logic [1:0] SH2_OS     = 2'b10;
    localparam logic [3:0] SH3_DATA   = 4'b0101;
    localparam logic [3:0] SH3_OS     = 4'b1010;
    localparam logic [3:0] D_SEL_DATA = 4'd8;

    // Widest lane slot (Gen3: 4-bit header over 128-bit payload).
    localparam int SLOT_W = 132;

    function automatic logic [4:0] bytes_per_block(input logic [1:0] gen);
        return (gen == GEN2) ? 5'd8 : 5'd16;
    endfunction

endpackage

// File: rtl/usb4_blk_pingpong.sv
// Two-entry block buffer. The head entry is the block being serialised;
// a push and a pop in the same cycle leave occupancy unchanged.
module usb4_blk_pingpong #(
    parameter int W = 8
) (
    input  logic         enc_clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic [1:0]   count
);

    logic [W-1:0] mem [2];
    logic         rd_ptr;
    logic         wr_ptr;

    // Pointer and occupancy tracking; flush empties without touching data.
    always_ff @(posedge enc_clk) begin
        if (rst || flush) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

    // Block storage, written on push only.
    always_ff @(posedge enc_clk) begin
        if (push) mem[wr_ptr] <= din;
    end

    assign dout = mem[rd_ptr];

endmodule

// File: rtl/usb4_rx_lane_decoder.sv
// USB4 receive lane decoder: sync header check, ping-pong buffering and
// byte serialisation of each lane's payload, with deskew enable.
//
// state     | meaning
// ST_IDLE   | buffer empty; an accepted good block emits byte 0 next cycle
// ST_SERIAL | emitting bytes of the head block, one per cycle
module usb4_rx_lane_decoder
    import usb4_dec_pkg::*;
#(
    parameter int NUM_LANES = 2,
    parameter int BLK_W     = 132,
    parameter int MAX_BYTES = 16
) (
    input  logic                       enc_clk,
    input  logic                       rst,
    input  logic                       enable_dec,
    input  logic [1:0]                 gen_speed,
    input  logic [3:0]                 d_sel,
    input  logic                       blk_valid,
    output logic                       blk_ready,
    input  logic [NUM_LANES*BLK_W-1:0] lane_rx_enc,
    output logic [NUM_LANES*8-1:0]     lane_rx,
    output logic                       byte_valid,
    output logic                       blk_start,
    output logic                       data_os,
    output logic                       sync_err,
    output logic                       enable_deskew
);

    localparam int PL_W   = MAX_BYTES * 8;
    localparam int PL_ALL = NUM_LANES * PL_W;
    localparam int PP_W   = PL_ALL + 1;

    logic                   en_eff;
    logic                   acc;
    logic                   push;
    logic                   pop;
    logic                   blk_good;
    logic                   blk_is_data;
    logic [NUM_LANES-1:0]   is_d;
    logic [NUM_LANES-1:0]   is_o;
    logic [PL_ALL-1:0]      payload_in;
    logic [PL_ALL-1:0]      head_payload;
    logic                   head_type;
    logic [NUM_LANES*8-1:0] first_bytes;
    logic [NUM_LANES*8-1:0] serial_bytes;
    logic [PP_W-1:0]        pp_dout;
    logic [1:0]             pp_count;
    logic [4:0]             idx;
    logic [4:0]             last_idx;
    dec_state_e             state;

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        logic [SLOT_W-1:0] slot;
        assign slot = SLOT_W'(lane_rx_enc[g*BLK_W +: BLK_W]);
        assign payload_in[g*PL_W +: PL_W] = slot[PL_W-1:0];
        assign first_bytes[g*8 +: 8]      = slot[7:0];
        assign serial_bytes[g*8 +: 8]     = 8'(head_payload[g*PL_W +: PL_W] >> {idx, 3'b000});
        assign is_d[g] = (gen_speed == GEN2) ? (slot[65:64] == SH2_DATA) : (slot[131:128] == SH3_DATA);
        assign is_o[g] = (gen_speed == GEN2) ? (slot[65:64] == SH2_OS)   : (slot[131:128] == SH3_OS);
    end

    // Block classification; lanes must all carry a legal and identical type.
    always_comb begin
        blk_is_data = 1'b0;
        blk_good    = 1'b0;
        if (gen_speed == GEN4) begin
            blk_is_data = (d_sel == D_SEL_DATA);
            blk_good    = 1'b1;
        end else begin
            blk_is_data = |is_d;
            blk_good    = (&(is_d | is_o)) & ~((|is_d) & (|is_o));
        end
    end

    assign en_eff    = enable_dec & (gen_speed != GEN_RSVD);
    assign blk_ready = (pp_count < 2'd2) & en_eff & ~rst;
    assign acc       = blk_valid & blk_ready;
    assign push      = acc & blk_good;
    assign last_idx  = bytes_per_block(gen_speed) - 5'd1;
    assign pop       = en_eff & (state == ST_SERIAL) & (idx == last_idx);

    usb4_blk_pingpong #(
        .W (PP_W)
    ) u_pingpong (
        .enc_clk (enc_clk),
        .rst     (rst),
        .flush   (~en_eff),
        .push    (push),
        .pop     (pop),
        .din     ({blk_is_data, payload_in}),
        .dout    (pp_dout),
        .count   (pp_count)
    );

    assign head_type    = pp_dout[PP_W-1];
    assign head_payload = pp_dout[PL_ALL-1:0];

    // Serialiser FSM with registered byte, framing and deskew outputs.
    always_ff @(posedge enc_clk) begin
        if (rst) begin
            state         <= ST_IDLE;
            idx           <= 5'd0;
            lane_rx       <= '0;
            byte_valid    <= 1'b0;
            blk_start     <= 1'b0;
            data_os       <= 1'b0;
            sync_err      <= 1'b0;
            enable_deskew <= 1'b0;
        end else if (!en_eff) begin
            state         <= ST_IDLE;
            idx           <= 5'd0;
            byte_valid    <= 1'b0;
            blk_start     <= 1'b0;
            sync_err      <= 1'b0;
            enable_deskew <= 1'b0;
        end else begin
            sync_err <= acc & ~blk_good;
            case (state)
                ST_IDLE: begin
                    if (push) begin
                        lane_rx    <= first_bytes;
                        byte_valid <= 1'b1;
                        blk_start  <= 1'b1;
                        data_os    <= blk_is_data;
                        idx        <= 5'd1;
                        state      <= ST_SERIAL;
                    end else begin
                        byte_valid <= 1'b0;
                        blk_start  <= 1'b0;
                    end
                    // Gen4 deskew follows blk_start; Gen2/3 latches on first byte.
                    if (gen_speed == GEN4) enable_deskew <= push;
                    else if (push)         enable_deskew <= 1'b1;
                end
                ST_SERIAL: begin
                    lane_rx    <= serial_bytes;
                    byte_valid <= 1'b1;
                    blk_start  <= (idx == 5'd0);
                    if (idx == 5'd0) data_os <= head_type;
                    enable_deskew <= (gen_speed == GEN4) ? (idx == 5'd0) : 1'b1;
                    if (idx == last_idx) begin
                        idx <= 5'd0;
                        if (pp_count == 2'd1 && !push) state <= ST_IDLE;
                    end else begin
                        idx <= idx + 5'd1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_usb4_rx_lane_decoder.sv
// Directed bench for the USB4 receive lane decoder (2 lanes, 132-bit slots).
module tb_usb4_rx_lane_decoder;

    localparam int NL = 2;
    localparam int BW = 132;
    localparam int MB = 16;

    logic             enc_clk = 1'b0;
    logic             rst;
    logic             enable_dec;
    logic [1:0]       gen_speed;
    logic [3:0]       d_sel;
    logic             blk_valid;
    logic             blk_ready;
    logic [NL*BW-1:0] lane_rx_enc;
    logic [NL*8-1:0]  lane_rx;
    logic             byte_valid;
    logic             blk_start;
    logic             data_os;
    logic             sync_err;
    logic             enable_deskew;

    int n_cmp = 0;
    int n_err = 0;

    always #5 enc_clk = ~enc_clk;

    usb4_rx_lane_decoder #(
        .NUM_LANES (NL),
        .BLK_W     (BW),
        .MAX_BYTES (MB)
    ) dut (
        .enc_clk       (enc_clk),
        .rst           (rst),
        .enable_dec    (enable_dec),
        .gen_speed     (gen_speed),
        .d_sel         (d_sel),
        .blk_valid     (blk_valid),
        .blk_ready     (blk_ready),
        .lane_rx_enc   (lane_rx_enc),
        .lane_rx       (lane_rx),
        .byte_valid    (byte_valid),
        .blk_start     (blk_start),
        .data_os       (data_os),
        .sync_err      (sync_err),
        .enable_deskew (enable_deskew)
    );

    task automatic tick;
        @(posedge enc_clk);
        #1;
    endtask

    // Encoded lane slot: payload byte i = base+i, header placed per mode.
    function automatic logic [BW-1:0] mk_blk(input logic [3:0] hdr, input logic [1:0] gen, input logic [7:0] base);
        logic [BW-1:0] b;
        b = '0;
        for (int i = 0; i < 16; i++) b[i*8 +: 8] = base + 8'(i);
        if (gen == 2'd2) begin
            b[127:64] = '0;
            b[65:64]  = hdr[1:0];
        end else if (gen == 2'd1) begin
            b[131:128] = hdr;
        end
        return b;
    endfunction

    task automatic set_mode(input logic [1:0] g);
        blk_valid  = 1'b0;
        enable_dec = 1'b0;
        tick();
        gen_speed  = g;
        enable_dec = 1'b1;
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1; enable_dec = 1'b1; gen_speed = 2'd1; d_sel = 4'd0;
        blk_valid = 1'b0; lane_rx_enc = '0;
        tick(); tick();
        n_cmp++;
        if ({byte_valid, blk_start, data_os, enable_deskew, sync_err, lane_rx} !== 21'd0) begin
            n_err++;
            $display("FAIL reset_outputs: got %h expected %h", {byte_valid, blk_start, data_os, enable_deskew, sync_err, lane_rx}, 21'd0);
        end
        n_cmp++;
        if (blk_ready !== 1'b0) begin n_err++; $display("FAIL reset_blk_ready: got %b expected 0", blk_ready); end
        rst = 1'b0;
        #1;
        n_cmp++;
        if (blk_ready !== 1'b1) begin n_err++; $display("FAIL release_blk_ready: got %b expected 1", blk_ready); end
    endtask

    task automatic test_gen3_basic;
        logic [20:0] exp;
        set_mode(2'd1);
        lane_rx_enc = {mk_blk(4'b0101, 2'd1, 8'h00), mk_blk(4'b0101, 2'd1, 8'h00)};
        blk_valid = 1'b1;
        tick();
        blk_valid = 1'b0;
        for (int i = 0; i < 16; i++) begin
            exp = {1'b1, (i == 0), 1'b1, 1'b1, 1'b0, 8'(i), 8'(i)};
            n_cmp++;
            if ({byte_valid, blk_start, data_os, enable_deskew, sync_err, lane_rx} !== exp) begin
                n_err++;
                $display("FAIL gen3_byte%0d: got %h expected %h", i, {byte_valid, blk_start, data_os, enable_deskew, sync_err, lane_rx}, exp);
            end
            tick();
        end
        exp = {1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h0F, 8'h0F};
        n_cmp++;
        if ({byte_valid, blk_start, data_os, enable_deskew, sync_err, lane_rx} !== exp) begin
            n_err++;
            $display("FAIL gen3_end: got %h expected %h", {byte_valid, blk_start, data_os, enable_deskew, sync_err, lane_rx}, exp);
        end
    endtask

    task automatic test_gen2_back_to_back;
        logic [20:0] exp;
        logic [7:0]  l0;
        set_mode(2'd2);
        lane_rx_enc = {mk_blk(4'b0010, 2'd2, 8'h90), mk_blk(4'b0010, 2'd2, 8'h10)};
        blk_valid = 1'b1;
        #1;
        n_cmp++;
        if (blk_ready !== 1'b1) begin n_err++; $display("FAIL b2b_ready_empty: got %b expected 1", blk_ready); end
        tick();
        lane_rx_enc = {mk_blk(4'b0001, 2'd2, 8'hA0), mk_blk(4'b0001, 2'd2, 8'h20)};
        for (int i = 0; i < 16; i++) begin
            #1;
            l0  = (i < 8) ? 8'h10 + 8'(i) : 8'h20 + 8'(i - 8);
            exp = {1'b1, (i == 0 || i == 8), (i >= 8), 1'b1, 1'b0, l0 + 8'h80, l0};
            n_cmp++;
            if ({byte_valid, blk_start, data_os, enable_deskew, sync_err, lane_rx} !== exp) begin
                n_err++;
                $display("FAIL b2b_byte%0d: got %h expected %h", i, {byte_valid, blk_start, data_os, enable_deskew, sync_err, lane_rx}, exp);
            end
            n_cmp++;
            if (blk_ready !== !(i >= 1 && i <= 6)) begin
                n_err++;
                $display("FAIL b2b_ready%0d: got %b expected %b", i, blk_ready, !(i >= 1 && i <= 6));
            end
            tick();
            if (i == 0) blk_valid = 1'b0;
        end
        #1;
        n_cmp++;
        if ({byte_valid, blk_start, data_os} !== 3'b001) begin
            n_err++;
            $display("FAIL b2b_end: got %b expected 001", {byte_valid, blk_start, data_os});
        end
    endtask

    task automatic test_sync_err;
        logic [20:0] exp;
        set_mode(2'd1);
        for (int k = 0; k < 2; k++) begin
            lane_rx_enc = {mk_blk((k == 0) ? 4'b0000 : 4'b1010, 2'd1, 8'hB0), mk_blk(4'b0101, 2'd1, 8'h30)};
            blk_valid = 1'b1;
            tick();
            blk_valid = 1'b0;
            #1;
            n_cmp++;
            if ({byte_valid, blk_start, sync_err, blk_ready} !== 4'b0011) begin
                n_err++;
                $display("FAIL sync_err_pulse%0d: got %b expected 0011", k, {byte_valid, blk_start, sync_err, blk_ready});
            end
            tick();
            n_cmp++;
            if ({byte_valid, blk_start, sync_err} !== 3'b000) begin
                n_err++;
                $display("FAIL sync_err_clear%0d: got %b expected 000", k, {byte_valid, blk_start, sync_err});
            end
        end
        lane_rx_enc = {mk_blk(4'b0101, 2'd1, 8'hC0), mk_blk(4'b0101, 2'd1, 8'h40)};
        blk_valid = 1'b1;
        tick();
        blk_valid = 1'b0;
        for (int i = 0; i < 16; i++) begin
            exp = {1'b1, (i == 0), 1'b1, 1'b1, 1'b0, 8'hC0 + 8'(i), 8'h40 + 8'(i)};
            n_cmp++;
            if ({byte_valid, blk_start, data_os, enable_deskew, sync_err, lane_rx} !== exp) begin
                n_err++;
                $display("FAIL after_err_byte%0d: got %h expected %h", i, {byte_valid, blk_start, data_os, enable_deskew, sync_err, lane_rx}, exp);
            end
            tick();
        end
        n_cmp++;
        if (byte_valid !== 1'b0) begin n_err++; $display("FAIL after_err_end: got %b expected 0", byte_valid); end
    endtask

    task automatic test_gen4;
        logic [20:0] exp;
        logic [7:0]  l0;
        set_mode(2'd0);
        d_sel = 4'd8;
        lane_rx_enc = {mk_blk(4'd0, 2'd0, 8'hD0), mk_blk(4'd0, 2'd0, 8'h50)};
        blk_valid = 1'b1;
        tick();
        d_sel = 4'd3;
        lane_rx_enc = {mk_blk(4'd0, 2'd0, 8'hE0), mk_blk(4'd0, 2'd0, 8'h60)};
        for (int i = 0; i < 32; i++) begin
            #1;
            l0  = (i < 16) ? 8'h50 + 8'(i) : 8'h60 + 8'(i - 16);
            exp = {1'b1, (i % 16 == 0), (i < 16), (i % 16 == 0), 1'b0, l0 + 8'h80, l0};
            n_cmp++;
            if ({byte_valid, blk_start, data_os, enable_deskew, sync_err, lane_rx} !== exp) begin
                n_err++;
                $display("FAIL gen4_byte%0d: got %h expected %h", i, {byte_valid, blk_start, data_os, enable_deskew, sync_err, lane_rx}, exp);
            end
            tick();
            if (i == 0) blk_valid = 1'b0;
        end
        #1;
        n_cmp++;
        if ({byte_valid, enable_deskew} !== 2'b00) begin
            n_err++;
            $display("FAIL gen4_end: got %b expected 00", {byte_valid, enable_deskew});
        end
    endtask

    task automatic test_enable_drop;
        logic [20:0] exp;
        set_mode(2'd1);
        lane_rx_enc = {mk_blk(4'b0101, 2'd1, 8'h80), mk_blk(4'b0101, 2'd1, 8'h00)};
        blk_valid = 1'b1;
        tick();
        lane_rx_enc = {mk_blk(4'b0101, 2'd1, 8'h90), mk_blk(4'b0101, 2'd1, 8'h10)};
        for (int i = 0; i < 6; i++) begin
            #1;
            exp = {1'b1, (i == 0), 1'b1, 1'b1, 1'b0, 8'h80 + 8'(i), 8'(i)};
            n_cmp++;
            if ({byte_valid, blk_start, data_os, enable_deskew, sync_err, lane_rx} !== exp) begin
                n_err++;
                $display("FAIL drop_byte%0d: got %h expected %h", i, {byte_valid, blk_start, data_os, enable_deskew, sync_err, lane_rx}, exp);
            end
            if (i < 5) begin
                tick();
                if (i == 0) blk_valid = 1'b0;
            end
        end
        enable_dec = 1'b0;
        #1;
        n_cmp++;
        if (blk_ready !== 1'b0) begin n_err++; $display("FAIL drop_ready_now: got %b expected 0", blk_ready); end
        tick();
        n_cmp++;
        if ({byte_valid, blk_start, enable_deskew, lane_rx} !== {3'b000, 8'h85, 8'h05}) begin
            n_err++;
            $display("FAIL drop_flush: got %h expected %h", {byte_valid, blk_start, enable_deskew, lane_rx}, {3'b000, 8'h85, 8'h05});
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++;
            if ({byte_valid, blk_ready} !== 2'b00) begin
                n_err++;
                $display("FAIL drop_hold%0d: got %b expected 00", i, {byte_valid, blk_ready});
            end
        end
        enable_dec = 1'b1;
        #1;
        n_cmp++;
        if (blk_ready !== 1'b1) begin n_err++; $display("FAIL drop_reenable_ready: got %b expected 1", blk_ready); end
        for (int i = 0; i < 2; i++) begin
            tick();
            n_cmp++;
            if (byte_valid !== 1'b0) begin n_err++; $display("FAIL drop_discard%0d: got %b expected 0", i, byte_valid); end
        end
    endtask

    task automatic test_reset_mid;
        logic [20:0] exp;
        set_mode(2'd1);
        lane_rx_enc = {mk_blk(4'b0101, 2'd1, 8'hA0), mk_blk(4'b0101, 2'd1, 8'h20)};
        blk_valid = 1'b1;
        tick();
        blk_valid = 1'b0;
        tick(); tick(); tick();
        exp = {1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'hA3, 8'h23};
        n_cmp++;
        if ({byte_valid, blk_start, data_os, enable_deskew, sync_err, lane_rx} !== exp) begin
            n_err++;
            $display("FAIL rstmid_byte3: got %h expected %h", {byte_valid, blk_start, data_os, enable_deskew, sync_err, lane_rx}, exp);
        end
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_cmp++;
            if ({byte_valid, blk_start, data_os, enable_deskew, sync_err, lane_rx, blk_ready} !== 22'd0) begin
                n_err++;
                $display("FAIL rstmid_zero%0d: got %h expected 0", i, {byte_valid, blk_start, data_os, enable_deskew, sync_err, lane_rx, blk_ready});
            end
        end
        rst = 1'b0;
        lane_rx_enc = {mk_blk(4'b0101, 2'd1, 8'hF0), mk_blk(4'b0101, 2'd1, 8'h70)};
        blk_valid = 1'b1;
        #1;
        n_cmp++;
        if (blk_ready !== 1'b1) begin n_err++; $display("FAIL rstmid_ready: got %b expected 1", blk_ready); end
        tick();
        blk_valid = 1'b0;
        exp = {1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'hF0, 8'h70};
        n_cmp++;
        if ({byte_valid, blk_start, data_os, enable_deskew, sync_err, lane_rx} !== exp) begin
            n_err++;
            $display("FAIL rstmid_first: got %h expected %h", {byte_valid, blk_start, data_os, enable_deskew, sync_err, lane_rx}, exp);
        end
        repeat (15) tick();
        exp = {1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'hFF, 8'h7F};
        n_cmp++;
        if ({byte_valid, blk_start, data_os, enable_deskew, sync_err, lane_rx} !== exp) begin
            n_err++;
            $display("FAIL rstmid_last: got %h expected %h", {byte_valid, blk_start, data_os, enable_deskew, sync_err, lane_rx}, exp);
        end
        tick();
        n_cmp++;
        if (byte_valid !== 1'b0) begin n_err++; $display("FAIL rstmid_idle: got %b expected 0", byte_valid); end
    endtask

    // Guard against a stuck simulation.
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Scenario sequence.
    initial begin
        test_reset();
        test_gen3_basic();
        test_gen2_back_to_back();
        test_sync_err();
        test_gen4();
        test_enable_drop();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/usb4_rx_lane_decoder.md
Name: usb4_rx_lane_decoder

Overview:
Parametrised receive-side block decoder for the USB4 logical layer. Accepts one encoded block per lane per handshake (Gen2 66-bit, Gen3 132-bit, Gen4 raw 128-bit), checks and strips the sync header, and serialises the payload to one byte per lane per cycle. It double-buffers blocks so the upstream can deliver back-to-back, and drives data/ordered-set classification and deskew enable toward the lane deskew block.

Parameters:
NUM_LANES, 2, number of lanes decoded in lock-step (1..4)
BLK_W, 132, encoded block width per lane slot (header plus payload)
MAX_BYTES, 16, payload bytes per block at the widest mode

Ports:
enc_clk  in  1  decoder clock
rst  in  1  synchronous reset, active-high
enable_dec  in  1  decoder enable; low flushes and halts serialisation
gen_speed  in  2  0=GEN4, 1=GEN3, 2=GEN2, 3=reserved (treated as not-enabled)
d_sel  in  4  Gen4 block-type select; 8 means transport data
blk_valid  in  1  encoded block(s) present on lane_rx_enc
blk_ready  out  1  block slot free; accept on blk_valid & blk_ready
lane_rx_enc  in  NUM_LANES*BLK_W  encoded block, lane n at [n*BLK_W +: BLK_W]
lane_rx  out  NUM_LANES*8  decoded byte per lane
byte_valid  out  1  lane_rx holds a valid byte this cycle
blk_start  out  1  lane_rx is byte 0 of a block
data_os  out  1  1 = transport data, 0 = ordered set, for current block
sync_err  out  1  one-cycle pulse: illegal sync header on any lane
enable_deskew  out  1  deskew enable

Behaviour:
- Reset (rst=1 at enc_clk edge): all outputs 0 except blk_ready=0 on the reset cycle then 1; buffers empty, byte counter 0, FSM IDLE.
- Block size: GEN2 8 bytes from bits [63:0], header [65:64]; GEN3 16 bytes from [127:0], header [131:128]; GEN4 16 bytes from [127:0], no header.
- Header check at accept: GEN2 2'b01 data, 2'b10 OS; GEN3 4'b0101 data, 4'b1010 OS; GEN4 data_os from d_sel==8. Any other header on any lane: sync_err pulses 1 cycle after accept, block dropped (never serialised), buffer slot not consumed. Lanes disagreeing on type also raise sync_err and drop.
- Buffer: two-entry ping-pong per lane. blk_ready = (entries < 2) & enable_dec & ~rst & gen_speed != 3.
- FSM: IDLE -> SERIAL when an entry holds a block; SERIAL -> IDLE after last byte if buffer empty, else stays SERIAL and starts the next block with no bubble.
- Latency: block accepted in cycle t while IDLE -> byte 0 on lane_rx with byte_valid=1, blk_start=1 in cycle t+1. Bytes emitted in ascending index (byte i = payload[i*8 +: 8]), one per cycle, no gaps while buffer non-empty.
- data_os registered with blk_start and held for the whole block.
- Simultaneous accept and last-byte pop: legal; occupancy unchanged; next block follows without bubble.
- enable_deskew: GEN2/GEN3 set on first emitted byte after enable, held while enable_dec; GEN4 pulses with blk_start only.
- enable_dec low: at next edge buffers flushed, counter 0, byte_valid/blk_start/enable_deskew 0, lane_rx holds last value.
- gen_speed change is only legal with enable_dec low; otherwise outputs undefined until next flush.
- Reset mid-block: partial block discarded, no further bytes.

Decomposition:
- usb4_dec_pkg: gen_speed encodings, sync header constants (SH2_DATA/SH2_OS/SH3_DATA/SH3_OS), D_SEL_DATA=8, function bytes_per_block(gen).
- Sub-module usb4_blk_pingpong: two-entry block buffer with push/pop/occupancy, instantiated once, width NUM_LANES*MAX_BYTES*8 plus type bit.

Test Plan:
- GEN3, 2 lanes, payload bytes 0x00..0x0F, header 4'b0101 -> 16 cycles byte_valid, lane_rx 0x00..0x0F both lanes, data_os=1, blk_start on first only.
- GEN2 back-to-back: OS block (2'b10) then data block (2'b01) with blk_valid held -> 16 contiguous bytes, data_os 0 for 8 then 1 for 8, blk_ready drops only when both slots full.
- GEN3 header 4'b0000 on lane 1 -> sync_err pulse 1 cycle after accept, no byte_valid, next good block decodes normally.
- GEN4 d_sel=8 then d_sel=3 -> data_os 1 then 0; enable_deskew pulses aligned with each blk_start.
- enable_dec dropped at byte 5 of GEN3 block with second block buffered -> byte_valid 0 next cycle, both blocks discarded, blk_ready 0 until re-enable.
- rst asserted mid-block -> all outputs 0 next cycle; first block after release emits byte 0 one cycle after accept.
